// File: rtl/divisor_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package divisor_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_dec.sv
// Loadable down-counter with a zero flag, used as the divider iteration counter.
module counter_dec #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/divisor_fd.sv
// Divider datapath: A/Q/B registers, trial subtractor and restore mux.
module divisor_fd #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_zero,
    input  logic             step,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2*WIDTH:0] aq_shift;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   diff;

    always_comb begin
        aq_shift = {a_q, q_q} << 1;
        a_shift  = aq_shift[2*WIDTH:WIDTH];
        diff     = a_shift - {1'b0, b_q};

        a_d = a_q;
        q_d = q_q;
        b_d = b_q;
        if (load) begin
            a_d = '0;
            q_d = q_in;
            b_d = b_in;
        end else if (load_zero) begin
            // Divide-by-zero result is parked in the regular registers so the outputs stay plain wires.
            a_d = {1'b0, q_in};
            q_d = '1;
            b_d = b_in;
        end else if (step) begin
            a_d = diff[WIDTH] ? a_shift : diff;
            q_d = {aq_shift[WIDTH-1:1], ~diff[WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            q_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            b_q <= b_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = a_q[WIDTH-1:0];

endmodule

// File: rtl/divisor_seq.sv
// Sequential unsigned restoring divider: IDLE/CALC/DONE control around divisor_fd.
module divisor_seq
    import divisor_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Q_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t state_q, state_d;
    logic   dz_q, dz_d;
    logic   b_zero;
    logic   accept;
    logic   load;
    logic   load_zero;
    logic   step;
    logic   cnt_zero;

    assign b_zero = (B_in == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = b_zero ? DONE : CALC;
            CALC:    if (cnt_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state_q == IDLE) && start;
        load      = accept && !b_zero;
        load_zero = accept && b_zero;
        step      = (state_q == CALC);
        busy      = (state_q == CALC);
        done      = (state_q == DONE);
        dz_d      = dz_q;
        if (accept) begin
            dz_d = b_zero;
        end
    end

    assign div_zero = dz_q;

    counter_dec #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (step),
        .load_val (CNT_W'(WIDTH - 1)),
        .zero     (cnt_zero)
    );

    divisor_fd #(
        .WIDTH(WIDTH)
    ) u_fd (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_zero (load_zero),
        .step      (step),
        .q_in      (Q_in),
        .b_in      (B_in),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq: directed scenarios plus randomised divisions.
module tb_divisor_seq;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] Q_in;
    logic [WIDTH-1:0] B_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;

    divisor_seq #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Q_in      (Q_in),
        .B_in      (B_in),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = q;
            e.dz = 1'b1;
        end else begin
            e.q  = q / b;
            e.r  = q % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Result checker: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_zero", 32'(div_zero), 32'(e.dz));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_quot"}, 32'(quotient), 32'd0);
        check({tag, "_rem"}, 32'(remainder), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_dz"}, 32'(div_zero), 32'd0);
    endtask

    task automatic run_div(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] b);
        int unsigned n;
        int unsigned lat_exp;
        @(negedge clk);
        Q_in  = q;
        B_in  = b;
        start = 1'b1;
        sb.push_back(model(q, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        Q_in  = WIDTH'($urandom);
        B_in  = WIDTH'($urandom);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        lat_exp = (b == 0) ? 1 : WIDTH + 1;
        check("latency", 32'(n), 32'(lat_exp));
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned d0;
        int          first;
        int          second;

        rst   = 1'b0;
        start = 1'b0;
        Q_in  = '0;
        B_in  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        run_div(8'd100, 8'd7);
        run_div(8'd255, 8'd1);
        run_div(8'd5, 8'd9);
        run_div(8'd77, 8'd0);

        // start re-pulsed mid-calculation must be ignored
        d0 = done_cnt;
        @(negedge clk);
        Q_in  = 8'd200;
        B_in  = 8'd3;
        start = 1'b1;
        sb.push_back(model(8'd200, 8'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        Q_in  = 8'd9;
        B_in  = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_restart", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check("overlap_done_count", done_cnt - d0, 32'd1);
        check("overlap_sb_empty", 32'(sb.size()), 32'd0);

        // asynchronous reset in the middle of a division
        d0 = done_cnt;
        @(negedge clk);
        Q_in  = 8'd123;
        B_in  = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("aborted_no_done", done_cnt - d0, 32'd0);
        run_div(8'd50, 8'd5);

        // start held high: back-to-back divisions
        first  = -1;
        second = -1;
        @(negedge clk);
        Q_in  = 8'd100;
        B_in  = 8'd7;
        start = 1'b1;
        sb.push_back(model(8'd100, 8'd7));
        sb.push_back(model(8'd100, 8'd7));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = int'(cyc);
                end else begin
                    second = int'(cyc);
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_start_gap", 32'(second - first), 32'(WIDTH + 2));
        repeat (3) @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            logic [WIDTH-1:0] rq;
            logic [WIDTH-1:0] rb;
            rq = WIDTH'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
            run_div(rq, rb);
        end
        run_div(8'd0, 8'd255);
        run_div(8'd255, 8'd255);

        repeat (3) @(negedge clk);
        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
